// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'h0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] regNum;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry write holding slot. A slot that is granted this cycle can take
// a new request on the same edge, so a streaming requester sees no bubble.
module rf_wr_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [ADDR_W-1:0] inReg,
    input  logic [DATA_W-1:0] inData,
    input  logic              grant,
    output logic              full,
    output logic [ADDR_W-1:0] slotReg,
    output logic [DATA_W-1:0] slotData
);

    assign inReady = !full || grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            full     <= 1'b0;
            slotReg  <= '0;
            slotData <= '0;
        end else if (inValid && inReady) begin
            full     <= 1'b1;
            slotReg  <= inReg;
            slotData <= inData;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the register file's single write port.
// Define RFARB_FIXED_PRIO_EN to replace round-robin with fixed A priority.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    // Handshake: a request transfers on a rising edge where x_valid and x_ready
    // are both high; while x_ready is low the requester holds reg/data stable.
    logic              fullA, fullB;
    logic              grantA, grantB;
    logic              loadA, loadB;
    logic              nextFullA, nextFullB;
    logic [ADDR_W-1:0] regA, regB, selReg;
    logic [DATA_W-1:0] dataA, dataB, selData;
    req_id_t           older;
`ifndef RFARB_FIXED_PRIO_EN
    req_id_t           rrPtr;
`endif

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) slotA (
        .clk(clk), .rst(rst),
        .inValid(a_valid), .inReady(a_ready), .inReg(a_reg), .inData(a_data),
        .grant(grantA), .full(fullA), .slotReg(regA), .slotData(dataA)
    );

    rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) slotB (
        .clk(clk), .rst(rst),
        .inValid(b_valid), .inReady(b_ready), .inReg(b_reg), .inData(b_data),
        .grant(grantB), .full(fullB), .slotReg(regB), .slotData(dataB)
    );

    assign loadA     = a_valid && a_ready;
    assign loadB     = b_valid && b_ready;
    assign nextFullA = loadA || (fullA && !grantA);
    assign nextFullB = loadB || (fullB && !grantB);

    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (fullA && fullB) begin
            if (regA == regB) begin
                grantA = (older == REQ_A);
            end else begin
`ifdef RFARB_FIXED_PRIO_EN
                grantA = 1'b1;
`else
                grantA = (rrPtr == REQ_A);
`endif
            end
            grantB = !grantA;
        end else begin
            grantA = fullA;
            grantB = fullB;
        end
    end

    assign selReg  = grantA ? regA : regB;
    assign selData = grantA ? dataA : dataB;
    assign busy    = fullA || fullB || wr_en;

    // A granted slot that refills holds younger data than a slot left waiting,
    // so age follows whichever slot was loaded on this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            older <= REQ_A;
        end else if (nextFullA && nextFullB) begin
            if (loadA && !loadB) begin
                older <= REQ_B;
            end else if (loadA || loadB) begin
                older <= REQ_A;
            end
        end
    end

`ifndef RFARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr <= REQ_A;
        end else if (fullA && fullB) begin
            rrPtr <= grantA ? REQ_B : REQ_A;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (grantA || grantB) begin
            wr_en   <= (selReg != ADDR_W'(REG_ZERO));
            wr_reg  <= selReg;
            wr_data <= selData;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios feeding a
// scoreboard of expected {reg, data} writes in program order.
module tb_regfile_wr_arbiter;
    import rf_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_reg, b_reg;
    logic [DW-1:0] a_data, b_data;
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          busy;

    logic [AW+DW-1:0] exp_q[$];
    wr_req_t          aPend[$];
    wr_req_t          bPend[$];
    int               assertCount = 0;
    int               failCount   = 0;
    int               wrCount     = 0;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic wr_req_t mkReq(input int r, input int d);
        wr_req_t q;
        q.regNum = AW'(r);
        q.data   = DW'(d);
        return q;
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (wr_en) begin
            wrCount++;
            if (exp_q.size() == 0) begin
                checkEq("spurious_wr_en", 64'(wr_en), 64'(0));
            end else begin
                checkEq("wr_port", 64'({wr_reg, wr_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    // mode 1: readies must alternate while both slots stay full; mode 2: a_ready stays high.
    task automatic runCycles(input int maxCyc, input int mode);
        int  k;
        bit  aFire, bFire;
        k = 0;
        while ((aPend.size() > 0 || bPend.size() > 0 || exp_q.size() > 0 || busy) && k < maxCyc) begin
            @(negedge clk);
            a_valid = (aPend.size() > 0);
            b_valid = (bPend.size() > 0);
            if (a_valid) begin a_reg = aPend[0].regNum; a_data = aPend[0].data; end
            if (b_valid) begin b_reg = bPend[0].regNum; b_data = bPend[0].data; end
            #1;
            if (mode == 1 && k >= 1 && k <= 9) begin
                checkEq("a_ready_alt", 64'(a_ready), 64'(k[0]));
                checkEq("b_ready_alt", 64'(b_ready), 64'(!k[0]));
            end
            if (mode == 2) checkEq("a_ready_zero", 64'(a_ready), 64'(1));
            aFire = a_valid && a_ready;
            bFire = b_valid && b_ready;
            @(posedge clk);
            if (aFire) void'(aPend.pop_front());
            if (bFire) void'(bPend.pop_front());
            #1;
            k++;
        end
        if (k >= maxCyc)
            checkEq("drain_timeout", 64'(aPend.size() + bPend.size() + exp_q.size()), 64'(0));
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic pushPair(input int ar, input int ad, input int br, input int bd, input bit aFirst);
        aPend.push_back(mkReq(ar, ad));
        bPend.push_back(mkReq(br, bd));
        if (aFirst) begin
            exp_q.push_back({AW'(ar), DW'(ad)});
            exp_q.push_back({AW'(br), DW'(bd)});
        end else begin
            exp_q.push_back({AW'(br), DW'(bd)});
            exp_q.push_back({AW'(ar), DW'(ad)});
        end
    endtask

    initial begin
        int wrBefore;
        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("rst_wr_en",   64'(wr_en),   64'(0));
        checkEq("rst_wr_reg",  64'(wr_reg),  64'(0));
        checkEq("rst_wr_data", 64'(wr_data), 64'(0));
        checkEq("rst_busy",    64'(busy),    64'(0));
        checkEq("rst_a_ready", 64'(a_ready), 64'(1));
        checkEq("rst_b_ready", 64'(b_ready), 64'(1));
        rst = 1'b1;

        // Single write and its two-edge latency
        @(negedge clk);
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h1234;
        exp_q.push_back({5'd9, 32'h1234});
        #1 checkEq("single_a_ready", 64'(a_ready), 64'(1));
        @(negedge clk);
        a_valid = 1'b0;
        checkEq("single_wr_en_e1", 64'(wr_en), 64'(0));
        checkEq("single_busy_e1",  64'(busy),  64'(1));
        @(negedge clk);
        checkEq("single_wr_en_e2", 64'(wr_en), 64'(1));
        @(negedge clk);
        checkEq("single_wr_en_e3", 64'(wr_en), 64'(0));
        checkEq("single_busy_e3",  64'(busy),  64'(0));

        // Simultaneous fill, different regs: pointer starts at A
        pushPair(8, 32'hAAAA, 10, 32'hBBBB, 1'b1);
        runCycles(20, 0);

        // Simultaneous fill, same reg: A is older even though pointer is at B
        pushPair(20, 32'h11, 20, 32'h22, 1'b1);
        runCycles(20, 0);

        // Different regs again: pointer now at B
        pushPair(8, 32'hAAAA, 10, 32'hBBBB, 1'b0);
        runCycles(20, 0);

        // B's reg-17 write is pending when A's reg-17 write arrives
        aPend.push_back(mkReq(3, 32'h33));
        aPend.push_back(mkReq(17, 32'h2));
        bPend.push_back(mkReq(17, 32'h1));
        exp_q.push_back({5'd3,  32'h33});
        exp_q.push_back({5'd17, 32'h1});
        exp_q.push_back({5'd17, 32'h2});
        runCycles(20, 0);

        // Write to $zero is consumed silently
        wrBefore = wrCount;
        aPend.push_back(mkReq(0, 32'hFFFF));
        runCycles(20, 2);
        repeat (2) @(negedge clk);
        checkEq("zero_no_write", 64'(wrCount - wrBefore), 64'(0));

        // Reset with both slots full discards everything
        @(negedge clk);
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h55;
        b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h66;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        checkEq("midrst_busy_before", 64'(busy), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkEq("midrst_wr_en",   64'(wr_en),   64'(0));
        checkEq("midrst_a_ready", 64'(a_ready), 64'(1));
        checkEq("midrst_b_ready", 64'(b_ready), 64'(1));
        checkEq("midrst_busy",    64'(busy),    64'(0));
        wrBefore = wrCount;
        repeat (4) @(negedge clk);
        checkEq("midrst_no_write", 64'(wrCount - wrBefore), 64'(0));

        // Streaming from both requesters: strict alternation starting with A
        for (int i = 0; i < 5; i++) begin
            pushPair(1 + i, 32'hA000 + i, 11 + i, 32'hB000 + i, 1'b1);
        end
        runCycles(40, 1);

        // Random single-requester traffic on nonzero regs
        for (int i = 0; i < 6; i++) begin
            int r;
            int d;
            r = $urandom_range(1, 31);
            d = $urandom_range(0, 32'h7fff_ffff);
            if (i[0]) begin
                bPend.push_back(mkReq(r, d));
            end else begin
                aPend.push_back(mkReq(r, d));
            end
            exp_q.push_back({AW'(r), DW'(d)});
            runCycles(20, 0);
        end

        repeat (3) @(negedge clk);
        checkEq("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
